fifo_checker: RTL

FIFO_CHECKER -- requirements
Module: fifo_checker

---
 rtl/fifo_checker.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fifo_checker.sv
// fifo_checker: occupancy-model scoreboard for a synchronous FIFO.
// Define FIFO_CHK_DATA_EN to add the shadow data memory and data_out check.
module fifo_checker #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          chk_en,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic [FIFO_WIDTH-1:0]         data_out,
    input  logic                          wr_ack,
    input  logic                          overflow,
    input  logic                          underflow,
    input  logic                          full,
    input  logic                          empty,
    input  logic                          almostfull,
    input  logic                          almostempty,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [7:0]                    err_code,
    output logic [7:0]                    first_err,
    output logic                          err_flag,
    output logic [CNT_W-1:0]              error_count,
    output logic [CNT_W-1:0]              correct_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_C  = OW'(FIFO_DEPTH);
    localparam logic [OW-1:0] DEPTH_M1 = OW'(FIFO_DEPTH - 1);
    localparam logic [OW-1:0] ONE_C    = OW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] count;
    logic          exp_wr_ack;
    logic          exp_overflow;
    logic          exp_underflow;

    logic          m_full;
    logic          m_empty;
    logic          m_afull;
    logic          m_aempty;
    logic          wr_ok;
    logic          rd_ok;
    logic [7:0]    mism;

    assign m_full   = (count == DEPTH_C);
    assign m_empty  = (count == '0);
    assign m_afull  = (count == DEPTH_M1);
    assign m_aempty = (count == ONE_C);

    // Full blocks the write even with a read pending; empty blocks the read.
    assign wr_ok = wr_en && !m_full;
    assign rd_ok = rd_en && !m_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            exp_wr_ack    <= 1'b0;
            exp_overflow  <= 1'b0;
            exp_underflow <= 1'b0;
        end else begin
            exp_wr_ack    <= wr_ok;
            exp_overflow  <= wr_en && m_full;
            exp_underflow <= rd_en && m_empty;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_CHK_DATA_EN
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] exp_data;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_data <= '0;
        end else if (rd_ok) begin
            exp_data <= mem[rd_ptr];
        end
    end

    always_comb begin
        mism    = 8'h00;
        mism[0] = (data_out != exp_data);
        mism[1] = (wr_ack != exp_wr_ack);
        mism[2] = (overflow != exp_overflow);
        mism[3] = (underflow != exp_underflow);
        mism[4] = (full != m_full);
        mism[5] = (empty != m_empty);
        mism[6] = (almostfull != m_afull);
        mism[7] = (almostempty != m_aempty);
    end
`else
    logic unused_data;
    assign unused_data = ^{data_in, data_out};

    always_comb begin
        mism    = 8'h00;
        mism[1] = (wr_ack != exp_wr_ack);
        mism[2] = (overflow != exp_overflow);
        mism[3] = (underflow != exp_underflow);
        mism[4] = (full != m_full);
        mism[5] = (empty != m_empty);
        mism[6] = (almostfull != m_afull);
        mism[7] = (almostempty != m_aempty);
    end
`endif

    // clr wins over the compare sampled in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_count   <= '0;
            correct_count <= '0;
            err_code      <= 8'h00;
            first_err     <= 8'h00;
        end else if (clr) begin
            error_count   <= '0;
            correct_count <= '0;
            err_code      <= 8'h00;
            first_err     <= 8'h00;
        end else if (chk_en) begin
            if (mism == 8'h00) begin
                if (correct_count != '1) begin
                    correct_count <= correct_count + CNT_W'(1);
                end
            end else begin
                if (error_count != '1) begin
                    error_count <= error_count + CNT_W'(1);
                end
                if (err_code == 8'h00) begin
                    first_err <= mism;
                end
                err_code <= err_code | mism;
            end
        end
    end

    assign occupancy = count;
    assign err_flag  = |err_code;

endmodule
